banked_dp_mem_sched: RTL and testbench

- Parametrised successor to the team's banked dual-port memory.
- Two independent request ports (A, B) share NUM_BANKS single-port banks, with word-interleaved addressing.
- Each port has its own fixed read and write latency.
- A per-bank slot scheduler guarantees that no bank is accessed twice on the same edge; a round-robin arbiter settles same-slot contention between ports.

---
 rtl/banked_dp_mem_sched_pkg.sv | 34 +++
 rtl/banked_dp_mem_sched_mem_bank.sv | 31 +++
 rtl/banked_dp_mem_sched.sv | 204 ++++++++++++++++++++
 tb/tb_banked_dp_mem_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_dp_mem_sched_pkg.sv
// Shared constants and types for the banked dual-port scheduled memory.
// Default geometry and latencies; the top module may override them per instance.
package pkg_banked;

  localparam int DATA_WIDTH  = 8;
  localparam int MEM_DEPTH   = 16;
  localparam int NUM_BANKS   = 4;
  localparam int ADDR_WIDTH  = $clog2(NUM_BANKS * MEM_DEPTH);
  localparam int WR_LATENCYA = 7;
  localparam int RD_LATENCYA = 5;
  localparam int WR_LATENCYB = 6;
  localparam int RD_LATENCYB = 6;

  function automatic int lat_max(input int l0, input int l1, input int l2, input int l3);
    int m;
    m = l0;
    m = (l1 > m) ? l1 : m;
    m = (l2 > m) ? l2 : m;
    m = (l3 > m) ? l3 : m;
    return m;
  endfunction

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_WIDTH = ADDR_WIDTH - BANK_BITS;
  localparam int LAT_MAX   = lat_max(WR_LATENCYA, RD_LATENCYA, WR_LATENCYB, RD_LATENCYB);

  typedef struct packed {
    logic                  we;
    logic [ROW_WIDTH-1:0]  row;
    logic [BANK_BITS-1:0]  bank;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/banked_dp_mem_sched_mem_bank.sv
// Single-port memory bank: one access per edge, read data registered on the access edge.
module mem_bank #(
  parameter int DATA_WIDTH = pkg_banked::DATA_WIDTH,
  parameter int MEM_DEPTH  = pkg_banked::MEM_DEPTH,
  parameter int ROW_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_WIDTH-1:0]  row,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array and read register; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[row] <= wdata;
      end else begin
        rdata_r <= mem_r[row];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/banked_dp_mem_sched.sv
// Two request ports sharing NUM_BANKS single-port banks; a per-bank slot reservation
// vector guarantees one access per bank per edge, round-robin settles same-slot ties.
module banked_dp_mem_sched #(
  parameter int DATA_WIDTH  = pkg_banked::DATA_WIDTH,
  parameter int MEM_DEPTH   = pkg_banked::MEM_DEPTH,
  parameter int NUM_BANKS   = pkg_banked::NUM_BANKS,
  parameter int ADDR_WIDTH  = $clog2(NUM_BANKS * MEM_DEPTH),
  parameter int WR_LATENCYA = pkg_banked::WR_LATENCYA,
  parameter int RD_LATENCYA = pkg_banked::RD_LATENCYA,
  parameter int WR_LATENCYB = pkg_banked::WR_LATENCYB,
  parameter int RD_LATENCYB = pkg_banked::RD_LATENCYB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [15:0]           conflict_cnt
);
  import pkg_banked::*;

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = ADDR_WIDTH - BANK_W;
  localparam int LAT_N  = lat_max(WR_LATENCYA, RD_LATENCYA, WR_LATENCYB, RD_LATENCYB);
  localparam int LAT_W  = $clog2(LAT_N + 1);
  localparam int NPIPE  = 4;

  // Pipe order: 0 = A write, 1 = A read, 2 = B write, 3 = B read.
  function automatic int pipe_lat(input int p);
    case (p)
      0:       return WR_LATENCYA;
      1:       return RD_LATENCYA;
      2:       return WR_LATENCYB;
      default: return RD_LATENCYB;
    endcase
  endfunction

  function automatic logic pipe_wr(input int p);
    return (p == 0) || (p == 2);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [ROW_W-1:0]      row;
    logic [BANK_W-1:0]     bank;
    logic [DATA_WIDTH-1:0] wdata;
  } slot_t;

  slot_t                 pipe_r     [NPIPE][LAT_N];
  slot_t                 push_s     [NPIPE];
  logic [LAT_N:0]        res_r      [NUM_BANKS];
  logic [LAT_N:0]        res_next_s [NUM_BANKS];
  logic                  bank_en_s  [NUM_BANKS];
  logic                  bank_we_s  [NUM_BANKS];
  logic [ROW_W-1:0]      bank_row_s [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wd_s  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rd_s  [NUM_BANKS];

  logic              prio_r;  // 1 = port B holds priority
  logic [15:0]       conflict_r;
  logic              a_rvalid_r, b_rvalid_r;
  logic [BANK_W-1:0] a_rbank_r, b_rbank_r;
  logic [DATA_WIDTH-1:0] a_hold_r, b_hold_r, a_rdata_s, b_rdata_s;

  logic [BANK_W-1:0] a_bank_s, b_bank_s;
  logic [ROW_W-1:0]  a_row_s, b_row_s;
  logic [LAT_W-1:0]  a_lat_s, b_lat_s;
  logic              a_free_s, b_free_s, contend_s, a_ready_s, b_ready_s, stall_s;

  assign a_bank_s  = a_addr[BANK_W-1:0];
  assign b_bank_s  = b_addr[BANK_W-1:0];
  assign a_row_s   = a_addr[ADDR_WIDTH-1:BANK_W];
  assign b_row_s   = b_addr[ADDR_WIDTH-1:BANK_W];
  assign a_lat_s   = a_we ? LAT_W'(WR_LATENCYA) : LAT_W'(RD_LATENCYA);
  assign b_lat_s   = b_we ? LAT_W'(WR_LATENCYB) : LAT_W'(RD_LATENCYB);
  assign a_free_s  = ~res_r[a_bank_s][a_lat_s];
  assign b_free_s  = ~res_r[b_bank_s][b_lat_s];
  assign contend_s = a_valid && b_valid && (a_bank_s == b_bank_s) &&
                     (a_lat_s == b_lat_s) && a_free_s;
  assign a_ready_s = !rst && a_valid && a_free_s && !(contend_s && prio_r);
  assign b_ready_s = !rst && b_valid && b_free_s && !(contend_s && !prio_r);
  assign stall_s   = (a_valid && !a_ready_s) || (b_valid && !b_ready_s);

  assign push_s[0] = '{valid: a_ready_s && a_we,  row: a_row_s, bank: a_bank_s, wdata: a_wdata};
  assign push_s[1] = '{valid: a_ready_s && !a_we, row: a_row_s, bank: a_bank_s, wdata: a_wdata};
  assign push_s[2] = '{valid: b_ready_s && b_we,  row: b_row_s, bank: b_bank_s, wdata: b_wdata};
  assign push_s[3] = '{valid: b_ready_s && !b_we, row: b_row_s, bank: b_bank_s, wdata: b_wdata};

  // Next reservation vector: book accepted slots, then age every slot by one edge.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      res_next_s[b] = (res_r[b]
        | ({(LAT_N+1){a_ready_s && (a_bank_s == BANK_W'(b))}} & ((LAT_N+1)'(1'b1) << a_lat_s))
        | ({(LAT_N+1){b_ready_s && (b_bank_s == BANK_W'(b))}} & ((LAT_N+1)'(1'b1) << b_lat_s)))
        >> 1'b1;
    end
  end

  // Bank drive from pipe heads; reservation makes the per-bank hits mutually exclusive.
  always_comb begin : bank_drive
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en_s[b]  = 1'b0;
      bank_we_s[b]  = 1'b0;
      bank_row_s[b] = '0;
      bank_wd_s[b]  = '0;
      for (int p = 0; p < NPIPE; p++) begin
        hit = !rst && pipe_r[p][0].valid && (pipe_r[p][0].bank == BANK_W'(b));
        bank_en_s[b]  = bank_en_s[b] | hit;
        bank_we_s[b]  = bank_we_s[b] | (hit && pipe_wr(p));
        bank_row_s[b] = bank_row_s[b] | ({ROW_W{hit}} & pipe_r[p][0].row);
        bank_wd_s[b]  = bank_wd_s[b] | ({DATA_WIDTH{hit}} & pipe_r[p][0].wdata);
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .ROW_WIDTH  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en_s[g]),
      .we    (bank_we_s[g]),
      .row   (bank_row_s[g]),
      .wdata (bank_wd_s[g]),
      .rdata (bank_rd_s[g])
    );
  end

  // Latency pipes, reservation vectors and round-robin priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPIPE; p++) begin
        for (int k = 0; k < LAT_N; k++) begin
          pipe_r[p][k] <= '0;
        end
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        res_r[b] <= '0;
      end
      prio_r <= 1'b0;
    end else begin
      for (int p = 0; p < NPIPE; p++) begin
        for (int k = 0; k < LAT_N - 1; k++) begin
          pipe_r[p][k] <= pipe_r[p][k+1];
        end
        pipe_r[p][LAT_N-1] <= '0;
        pipe_r[p][pipe_lat(p)-1] <= push_s[p];
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        res_r[b] <= res_next_s[b];
      end
      // A contended grant hands priority to the port that lost it.
      prio_r <= contend_s ? a_ready_s : prio_r;
    end
  end

  assign a_rdata_s = a_rvalid_r ? bank_rd_s[a_rbank_r] : a_hold_r;
  assign b_rdata_s = b_rvalid_r ? bank_rd_s[b_rbank_r] : b_hold_r;

  // Read return tracking, held read data and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      a_rbank_r  <= '0;
      b_rbank_r  <= '0;
      a_hold_r   <= '0;
      b_hold_r   <= '0;
      conflict_r <= 16'd0;
    end else begin
      a_rvalid_r <= pipe_r[1][0].valid;
      b_rvalid_r <= pipe_r[3][0].valid;
      a_rbank_r  <= pipe_r[1][0].bank;
      b_rbank_r  <= pipe_r[3][0].bank;
      a_hold_r   <= a_rdata_s;
      b_hold_r   <= b_rdata_s;
      conflict_r <= (stall_s && (conflict_r != 16'hFFFF)) ? conflict_r + 16'd1 : conflict_r;
    end
  end

  assign a_ready      = a_ready_s;
  assign b_ready      = b_ready_s;
  assign a_rvalid     = a_rvalid_r;
  assign b_rvalid     = b_rvalid_r;
  assign a_rdata      = a_rdata_s;
  assign b_rdata      = b_rdata_s;
  assign conflict_cnt = conflict_r;

endmodule

// File: tb/tb_banked_dp_mem_sched.sv
// Bench for banked_dp_mem_sched: absolute-time booking model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_banked_dp_mem_sched;

  localparam int LWA = 7, LRA = 5, LWB = 6, LRB = 6, NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_valid, a_we, a_ready, a_rvalid, b_valid, b_we, b_ready, b_rvalid;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [15:0] conflict_cnt;

  logic p6_a_valid, p6_a_we, p6_a_ready, p6_a_rvalid, p6_b_valid, p6_b_we, p6_b_ready, p6_b_rvalid;
  logic [5:0] p6_a_addr, p6_b_addr;
  logic [7:0] p6_a_wdata, p6_b_wdata, p6_a_rdata, p6_b_rdata;
  logic [15:0] p6_conflict_cnt;

  int checks = 0;
  int errors = 0;

  banked_dp_mem_sched dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .conflict_cnt(conflict_cnt)
  );

  banked_dp_mem_sched #(.RD_LATENCYA(6)) dut6 (
    .clk(clk), .rst(rst),
    .a_valid(p6_a_valid), .a_ready(p6_a_ready), .a_we(p6_a_we), .a_addr(p6_a_addr),
    .a_wdata(p6_a_wdata), .a_rvalid(p6_a_rvalid), .a_rdata(p6_a_rdata),
    .b_valid(p6_b_valid), .b_ready(p6_b_ready), .b_we(p6_b_we), .b_addr(p6_b_addr),
    .b_wdata(p6_b_wdata), .b_rvalid(p6_b_rvalid), .b_rdata(p6_b_rdata),
    .conflict_cnt(p6_conflict_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: bookings keyed by absolute edge number
  typedef struct {
    longint     at;
    bit         port_b;
    bit         we;
    int         addr;
    logic [7:0] data;
  } op_t;

  logic [7:0] mem_m [64];
  op_t        ops [$];
  bit         booked [longint];
  bit         prio_m;
  bit         live = 1'b0;
  longint     edge_n = 0;
  bit         exp_arv, exp_brv;
  logic [7:0] exp_ard, exp_brd;
  int         exp_cnt;

  function automatic longint bk(input longint e, input int b);
    return e * NB + b;
  endfunction

  always @(negedge clk) begin : cmp
    int la, lb, ba, bb;
    bit fa, fb, cont, era, erb;
    la = a_we ? LWA : LRA;
    lb = b_we ? LWB : LRB;
    ba = int'(a_addr) % NB;
    bb = int'(b_addr) % NB;
    fa = !booked.exists(bk(edge_n + la, ba));
    fb = !booked.exists(bk(edge_n + lb, bb));
    cont = a_valid && b_valid && (ba == bb) && (la == lb) && fa;
    era = !rst && a_valid && fa && !(cont && prio_m);
    erb = !rst && b_valid && fb && !(cont && !prio_m);
    if (live) begin
      chk("a_ready", 32'(a_ready), 32'(era));
      chk("b_ready", 32'(b_ready), 32'(erb));
      chk("a_rvalid", 32'(a_rvalid), 32'(exp_arv));
      chk("b_rvalid", 32'(b_rvalid), 32'(exp_brv));
      chk("a_rdata", 32'(a_rdata), 32'(exp_ard));
      chk("b_rdata", 32'(b_rdata), 32'(exp_brd));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    end
    // advance the model across the coming edge
    if (rst) begin
      ops.delete();
      booked.delete();
      prio_m = 1'b0;
      exp_arv = 1'b0; exp_brv = 1'b0;
      exp_ard = 8'h00; exp_brd = 8'h00;
      exp_cnt = 0;
      live = 1'b1;
    end else begin
      if ((a_valid && !era) || (b_valid && !erb)) exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
      if (cont) prio_m = era ? 1'b1 : 1'b0;
      if (era) begin
        booked[bk(edge_n + la, ba)] = 1'b1;
        ops.push_back('{edge_n + la, 1'b0, a_we, int'(a_addr), a_wdata});
      end
      if (erb) begin
        booked[bk(edge_n + lb, bb)] = 1'b1;
        ops.push_back('{edge_n + lb, 1'b1, b_we, int'(b_addr), b_wdata});
      end
      exp_arv = 1'b0;
      exp_brv = 1'b0;
      for (int i = ops.size() - 1; i >= 0; i--) begin
        if (ops[i].at == edge_n) begin
          if (ops[i].we) mem_m[ops[i].addr] = ops[i].data;
          else if (ops[i].port_b) begin exp_brv = 1'b1; exp_brd = mem_m[ops[i].addr]; end
          else begin exp_arv = 1'b1; exp_ard = mem_m[ops[i].addr]; end
          ops.delete(i);
        end
      end
    end
    edge_n++;
  end

  // ---------------- stimulus helpers
  task automatic drv(input logic av, input logic awe, input logic [5:0] aad, input logic [7:0] awd,
                     input logic bv, input logic bwe, input logic [5:0] bad, input logic [7:0] bwd);
    a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p6_drv(input logic av, input logic bv);
    p6_a_valid = av; p6_a_we = 1'b0; p6_a_addr = 6'd2; p6_a_wdata = 8'h00;
    p6_b_valid = bv; p6_b_we = 1'b0; p6_b_addr = 6'd6; p6_b_wdata = 8'h00;
    #1;
  endtask

  initial begin
    bit got;
    int n, first, last;
    logic [7:0] got_d [4];

    rst = 1'b1;
    idle();
    p6_drv(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_conflict", 32'(conflict_cnt), 32'd0);
    chk("reset_a_rvalid", 32'(a_rvalid), 32'd0);

    // same-slot contention on bank 2 with equal latencies: A, B, A
    p6_drv(1'b1, 1'b1);
    chk("rr0_a_ready", 32'(p6_a_ready), 32'd1);
    chk("rr0_b_ready", 32'(p6_b_ready), 32'd0);
    step();
    chk("rr1_a_ready", 32'(p6_a_ready), 32'd0);
    chk("rr1_b_ready", 32'(p6_b_ready), 32'd1);
    step();
    chk("rr2_a_ready", 32'(p6_a_ready), 32'd1);
    chk("rr2_b_ready", 32'(p6_b_ready), 32'd0);
    step();
    p6_drv(1'b0, 1'b0);
    chk("rr_conflict", 32'(p6_conflict_cnt), 32'd3);

    // preload: addr 0..3 = 40..43, addr 9 = 11
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 6'(i), 8'h40 + 8'(i), 1'b0, 1'b0, 6'd0, 8'h00);
      chk("preload_ready", 32'(a_ready), 32'd1);
      step();
    end
    drv(1'b1, 1'b1, 6'd9, 8'h11, 1'b0, 1'b0, 6'd0, 8'h00);
    step();
    idle();
    repeat (10) step();

    // write-then-read collision on addr 5
    drv(1'b1, 1'b1, 6'd5, 8'hA5, 1'b0, 1'b0, 6'd0, 8'h00);
    step();
    drv(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd5, 8'h00);
    chk("t1_b_ready_c1", 32'(b_ready), 32'd0);
    step();
    drv(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd5, 8'h00);
    chk("t1_b_ready_c2", 32'(b_ready), 32'd1);
    step();
    idle();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (b_rvalid) got = 1'b1;
    end
    chk("t1_b_rvalid_seen", 32'(got), 32'd1);
    chk("t1_b_rdata", 32'(b_rdata), 32'hA5);
    chk("t1_conflict", 32'(conflict_cnt), 32'd1);
    repeat (4) step();

    // streaming reads of addr 0..3
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, 6'(i), 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
      chk("t2_a_ready", 32'(a_ready), 32'd1);
      step();
    end
    idle();
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (a_rvalid) begin
        if (n < 4) got_d[n] = a_rdata;
        if (first < 0) first = i;
        last = i;
        n++;
      end
    end
    chk("t2_count", 32'(n), 32'd4);
    chk("t2_consecutive", 32'(last - first), 32'd3);
    for (int k = 0; k < 4; k++) chk("t2_data", 32'(got_d[k]), 32'h40 + 32'(k));

    // mixed latencies on bank 3: A read slot 5, B write slot 6
    drv(1'b1, 1'b0, 6'd3, 8'h00, 1'b1, 1'b1, 6'd7, 8'h77);
    chk("t4_a_ready", 32'(a_ready), 32'd1);
    chk("t4_b_ready", 32'(b_ready), 32'd1);
    step();
    idle();
    step();
    chk("t4_conflict", 32'(conflict_cnt), 32'd1);
    repeat (10) step();

    // reset mid-flight: write of 22 to addr 9 and a B read are dropped
    drv(1'b1, 1'b1, 6'd9, 8'h22, 1'b0, 1'b0, 6'd0, 8'h00);
    step();
    drv(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd0, 8'h00);
    step();
    idle();
    step();
    rst = 1'b1;
    drv(1'b1, 1'b0, 6'd1, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    chk("t5_ready_in_rst", 32'(a_ready), 32'd0);
    step();
    rst = 1'b0;
    idle();
    chk("t5_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("t5_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("t5_conflict", 32'(conflict_cnt), 32'd0);
    chk("t5_a_rdata", 32'(a_rdata), 32'd0);
    repeat (10) step();
    drv(1'b1, 1'b0, 6'd9, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    step();
    idle();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (a_rvalid) got = 1'b1;
    end
    chk("t5_a_rvalid_seen", 32'(got), 32'd1);
    chk("t5_a_rdata_old", 32'(a_rdata), 32'h11);

    // saturation: B streams bank 1 reads, A's read of bank 1 stays blocked
    drv(1'b1, 1'b0, 6'd1, 8'h00, 1'b1, 1'b0, 6'd1, 8'h00);
    repeat (70000) step();
    chk("t6_saturated", 32'(conflict_cnt), 32'hFFFF);
    step();
    chk("t6_held", 32'(conflict_cnt), 32'hFFFF);
    idle();
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
